// File: rtl/mem_arbiter_if.sv
// Handshake and memory bus shared by the arbiter, its two requesters and the block memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int AW = 5,
    parameter int BW = 256
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ready;
    logic [BW-1:0] i_data;

    logic          d_req;
    logic          d_wen;
    logic [AW-1:0] d_addr;
    logic [BW-1:0] d_wdata;
    logic          d_ready;
    logic [BW-1:0] d_data;

    logic          mem_ren;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_din;
    logic          mem_ready;
    logic [BW-1:0] mem_dout;

    modport slave (
        input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_ready, mem_dout,
        output i_ready, i_data, d_ready, d_data, mem_ren, mem_wen, mem_addr, mem_din
    );

    modport master (
        output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_ready, mem_dout,
        input  i_ready, i_data, d_ready, d_data, mem_ren, mem_wen, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) block memory arbiter with round-robin tie-break.
//   state  | meaning
//   IDLE   | waiting for a request; grant latches address (and D direction/wdata)
//   SERV_I | instruction read in flight, waiting for mem_ready
//   SERV_D | data read or write in flight, waiting for mem_ready
//   GAP    | one cycle with memory enables low so the memory restarts its delay
module mem_arbiter #(
    parameter int WORD_SIZE  = 32,
    parameter int BLOCK_SIZE = 8,
    parameter int MEM_SIZE   = 32
) (
    input  logic           clock,
    input  logic           reset,
    mem_arbiter_if.slave   bus
);
    localparam int AW = $clog2(MEM_SIZE);
    localparam int BW = WORD_SIZE * BLOCK_SIZE;

    typedef enum logic [1:0] {IDLE, SERV_I, SERV_D, GAP} state_t;

    state_t        state_q;
    state_t        state_d;
    logic          grant_i;
    logic          grant_d;
    logic          done;

    logic          last_d_q;
    logic [AW-1:0] addr_q;
    logic          wen_q;
    logic [BW-1:0] wdata_q;
    logic [BW-1:0] i_data_q;
    logic [BW-1:0] d_data_q;
    logic          i_ready_q;
    logic          d_ready_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // On a tie, I wins only if D held the previous grant.
    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_req && (!bus.d_req || last_d_q)) begin
                    grant_i = 1'b1;
                    state_d = SERV_I;
                end else if (bus.d_req) begin
                    grant_d = 1'b1;
                    state_d = SERV_D;
                end
            end
            SERV_I, SERV_D: begin
                if (bus.mem_ready) begin
                    done    = 1'b1;
                    state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_d_q  <= 1'b1;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            i_data_q  <= '0;
            d_data_q  <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
        end else begin
            i_ready_q <= done && (state_q == SERV_I);
            d_ready_q <= done && (state_q == SERV_D);
            if (grant_i) begin
                addr_q   <= bus.i_addr;
                last_d_q <= 1'b0;
            end
            if (grant_d) begin
                addr_q   <= bus.d_addr;
                wen_q    <= bus.d_wen;
                wdata_q  <= bus.d_wdata;
                last_d_q <= 1'b1;
            end
            if (done && (state_q == SERV_I)) begin
                i_data_q <= bus.mem_dout;
            end
            if (done && (state_q == SERV_D) && !wen_q) begin
                d_data_q <= bus.mem_dout;
            end
        end
    end

    assign bus.mem_ren  = (state_q == SERV_I) || ((state_q == SERV_D) && !wen_q);
    assign bus.mem_wen  = (state_q == SERV_D) && wen_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_din  = wdata_q;
    assign bus.i_ready  = i_ready_q;
    assign bus.i_data   = i_data_q;
    assign bus.d_ready  = d_ready_q;
    assign bus.d_data   = d_data_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: 15-cycle block memory model, directed requests,
// and a scoreboard monitor that checks every ready pulse against queued expectations.
module tb_mem_arbiter;
    localparam int WORD_SIZE  = 32;
    localparam int BLOCK_SIZE = 8;
    localparam int MEM_SIZE   = 32;
    localparam int AW         = $clog2(MEM_SIZE);
    localparam int BW         = WORD_SIZE * BLOCK_SIZE;
    localparam int MEM_DELAY  = 15;

    typedef struct {
        bit            port_d;
        logic [BW-1:0] data;
    } exp_t;

    logic clock;
    logic reset;
    int   n_total = 0;
    int   n_pass  = 0;
    exp_t sb[$];

    mem_arbiter_if #(.AW(AW), .BW(BW)) bus ();

    mem_arbiter #(
        .WORD_SIZE (WORD_SIZE),
        .BLOCK_SIZE(BLOCK_SIZE),
        .MEM_SIZE  (MEM_SIZE)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [BW-1:0] blk(input int n);
        return {BLOCK_SIZE{WORD_SIZE'(n)}};
    endfunction

    // Memory model: ready in the 16th cycle of an enable run; reloads block n = n on reset.
    logic [BW-1:0] mem [MEM_SIZE];
    int            mem_cnt;

    always @(posedge clock) begin
        if (!reset) begin
            mem_cnt <= 0;
            for (int n = 0; n < MEM_SIZE; n++) mem[n] <= blk(n);
        end else begin
            if (bus.mem_ren || bus.mem_wen) mem_cnt <= mem_cnt + 1;
            else                            mem_cnt <= 0;
            if (bus.mem_ready && bus.mem_wen) mem[bus.mem_addr] <= bus.mem_din;
        end
    end

    assign bus.mem_ready = (bus.mem_ren || bus.mem_wen) && (mem_cnt == MEM_DELAY);
    assign bus.mem_dout  = mem[bus.mem_addr];

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic pop_check(input bit port_d, input logic [BW-1:0] data);
        exp_t e;
        if (sb.size() == 0) begin
            check(port_d ? "unexpected_d_ready" : "unexpected_i_ready", 1, 0);
        end else begin
            e = sb.pop_front();
            check("ready_port", BW'(port_d), BW'(e.port_d));
            check(port_d ? "d_data" : "i_data", data, e.data);
        end
    endtask

    always @(negedge clock) begin
        check("ready_exclusive", BW'(bus.i_ready && bus.d_ready), 0);
        check("mem_en_exclusive", BW'(bus.mem_ren && bus.mem_wen), 0);
        if (bus.i_ready) pop_check(1'b0, bus.i_data);
        if (bus.d_ready) pop_check(1'b1, bus.d_data);
    end

    function automatic exp_t mk(input bit port_d, input logic [BW-1:0] data);
        exp_t e;
        e.port_d = port_d;
        e.data   = data;
        return e;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Called on the negedge just after a grant; returns edges until the port's ready.
    task automatic wait_ready(input bit port_d, output int lat);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clock);
            if (port_d ? bus.d_ready : bus.i_ready) begin
                lat = k;
                return;
            end
        end
        check("ready_timeout", 1, 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_mem_ren"},  BW'(bus.mem_ren),  0);
        check({tag, "_mem_wen"},  BW'(bus.mem_wen),  0);
        check({tag, "_i_ready"},  BW'(bus.i_ready),  0);
        check({tag, "_d_ready"},  BW'(bus.d_ready),  0);
        check({tag, "_mem_addr"}, BW'(bus.mem_addr), 0);
        check({tag, "_mem_din"},  bus.mem_din,       0);
        check({tag, "_i_data"},   bus.i_data,        0);
        check({tag, "_d_data"},   bus.d_data,        0);
    endtask

    initial begin
        int            lat;
        int            gaps;
        int            pulses;
        logic [BW-1:0] a5;
        a5 = {(BW/8){8'hA5}};

        reset       = 1'b0;
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_wen   = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        #2;
        check_zero_outputs("reset");
        idle(3);
        reset = 1'b1;
        idle(2);

        // Tie after reset: I first; I held high re-ties with D, which now wins.
        bus.i_req  = 1'b1;
        bus.i_addr = AW'(4);
        bus.d_req  = 1'b1;
        bus.d_wen  = 1'b0;
        bus.d_addr = AW'(9);
        sb.push_back(mk(1'b0, blk(4)));
        sb.push_back(mk(1'b1, blk(9)));
        sb.push_back(mk(1'b0, blk(4)));
        @(posedge clock);
        @(negedge clock);
        check("tie1_mem_ren",  BW'(bus.mem_ren),  1);
        check("tie1_mem_addr", BW'(bus.mem_addr), 4);
        wait_ready(1'b0, lat);
        check("tie1_i_latency", BW'(lat), MEM_DELAY + 1);
        @(negedge clock);
        check("tie_idle_mem_ren", BW'(bus.mem_ren), 0);
        @(negedge clock);
        check("tie2_d_first_ren",  BW'(bus.mem_ren),  1);
        check("tie2_d_first_addr", BW'(bus.mem_addr), 9);
        wait_ready(1'b1, lat);
        check("tie2_d_latency", BW'(lat), MEM_DELAY + 1);
        bus.d_req = 1'b0;
        idle(2);
        check("tie3_i_addr", BW'(bus.mem_addr), 4);
        wait_ready(1'b0, lat);
        bus.i_req = 1'b0;
        idle(3);

        // Single instruction read of block 5.
        bus.i_req  = 1'b1;
        bus.i_addr = AW'(5);
        sb.push_back(mk(1'b0, blk(5)));
        @(posedge clock);
        @(negedge clock);
        check("i5_mem_ren",  BW'(bus.mem_ren),  1);
        check("i5_mem_wen",  BW'(bus.mem_wen),  0);
        check("i5_mem_addr", BW'(bus.mem_addr), 5);
        wait_ready(1'b0, lat);
        bus.i_req = 1'b0;
        check("i5_latency", BW'(lat), MEM_DELAY + 1);
        check("i5_gap_mem_ren", BW'(bus.mem_ren), 0);
        idle(3);

        // Data write of 0xA5 to block 3; d_data keeps block 9, then read back.
        bus.d_req   = 1'b1;
        bus.d_wen   = 1'b1;
        bus.d_addr  = AW'(3);
        bus.d_wdata = a5;
        sb.push_back(mk(1'b1, blk(9)));
        @(posedge clock);
        @(negedge clock);
        check("wr_mem_wen",  BW'(bus.mem_wen),  1);
        check("wr_mem_ren",  BW'(bus.mem_ren),  0);
        check("wr_mem_addr", BW'(bus.mem_addr), 3);
        check("wr_mem_din",  bus.mem_din,       a5);
        wait_ready(1'b1, lat);
        bus.d_req = 1'b0;
        check("wr_latency", BW'(lat), MEM_DELAY + 1);
        idle(3);
        bus.d_req   = 1'b1;
        bus.d_wen   = 1'b0;
        bus.d_wdata = '0;
        sb.push_back(mk(1'b1, a5));
        @(posedge clock);
        @(negedge clock);
        wait_ready(1'b1, lat);
        bus.d_req = 1'b0;
        idle(3);

        // Address change after grant must not affect the transaction.
        bus.i_req  = 1'b1;
        bus.i_addr = AW'(5);
        sb.push_back(mk(1'b0, blk(5)));
        @(posedge clock);
        @(negedge clock);
        bus.i_addr = AW'(7);
        @(negedge clock);
        check("latch_mem_addr", BW'(bus.mem_addr), 5);
        wait_ready(1'b0, lat);
        bus.i_req = 1'b0;
        idle(3);

        // Reset at cycle 8 of an I read: outputs clear at once and no ready follows.
        bus.i_req  = 1'b1;
        bus.i_addr = AW'(6);
        @(posedge clock);
        @(negedge clock);
        idle(8);
        #2;
        reset = 1'b0;
        #1;
        check_zero_outputs("midrst");
        bus.i_req = 1'b0;
        idle(3);
        reset  = 1'b1;
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clock);
            if (bus.i_ready) pulses++;
        end
        check("midrst_no_i_ready", BW'(pulses), 0);
        bus.i_req  = 1'b1;
        bus.i_addr = AW'(10);
        sb.push_back(mk(1'b0, blk(10)));
        @(posedge clock);
        @(negedge clock);
        check("postrst_mem_addr", BW'(bus.mem_addr), 10);
        wait_ready(1'b0, lat);
        bus.i_req = 1'b0;
        check("postrst_latency", BW'(lat), MEM_DELAY + 1);
        idle(3);

        // Held i_req: second read follows after the GAP cycle and one IDLE sample.
        bus.i_req  = 1'b1;
        bus.i_addr = AW'(2);
        sb.push_back(mk(1'b0, blk(2)));
        sb.push_back(mk(1'b0, blk(2)));
        @(posedge clock);
        @(negedge clock);
        wait_ready(1'b0, lat);
        check("held1_latency", BW'(lat), MEM_DELAY + 1);
        gaps = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (bus.mem_ren) break;
            gaps++;
        end
        check("held_ren_low_cycles", BW'(gaps), 2);
        check("held2_mem_addr", BW'(bus.mem_addr), 2);
        wait_ready(1'b0, lat);
        bus.i_req = 1'b0;
        check("held2_latency", BW'(lat), MEM_DELAY + 1);
        idle(5);

        check("scoreboard_drained", BW'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
